// File: rtl/imm_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package imm_enc_pkg;

   localparam int unsigned INST_W = 32;
   localparam int unsigned IMM_W  = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned FMT_W  = 3;

   typedef enum logic [FMT_W-1:0] {
      I_ALU   = 3'd0,
      I_SHIFT = 3'd1,
      I_LOAD  = 3'd2,
      S       = 3'd3,
      B       = 3'd4,
      JAL     = 3'd5,
      JALR    = 3'd6
   } fmt_e;

   typedef enum logic [1:0] {
      Q_EMPTY = 2'd0,
      Q_ONE   = 2'd1,
      Q_FULL  = 2'd2
   } q_state_e;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [6:0] F7_ZERO = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic              err;
   } enc_word_t;

   // True when imm[IMM_W-1:lo] are all equal, i.e. imm fits a (lo+1)-bit signed field.
   function automatic logic imm_fits(input logic [IMM_W-1:0] imm, input int unsigned lo);
      logic [IMM_W-1:0] hi;
      hi = IMM_W'($signed(imm) >>> lo);
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bus of the instruction encoder.
interface inst_encoder_if;
   import imm_enc_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [FMT_W-1:0]      in_fmt;
   logic [REG_W-1:0]      in_rd;
   logic [REG_W-1:0]      in_rs1;
   logic [REG_W-1:0]      in_rs2;
   logic [2:0]            in_funct3;
   logic [6:0]            in_funct7;
   logic [IMM_W-1:0]      in_imm;
   logic                  out_valid;
   logic                  out_ready;
   logic [INST_W-1:0]     out_inst;
   logic [ADDR_W-1:0]     out_addr;
   logic                  out_err;

   modport master (
      output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_addr, out_err
   );

   modport slave (
      input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_addr, out_err
   );
endinterface

// File: rtl/enc_fifo2.sv
// Two-entry valid/ready queue; head is a register so the output holds its last value when empty.
module enc_fifo2
   import imm_enc_pkg::*;
#(
   parameter int unsigned WIDTH = 33
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push_valid,
   output logic             push_ready_c,
   input  logic [WIDTH-1:0] push_data,
   output logic             pop_valid,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] pop_data
);

   q_state_e         state, state_nxt;
   logic [WIDTH-1:0] head, head_nxt;
   logic [WIDTH-1:0] tail, tail_nxt;
   logic             push, pop;

   assign pop_valid    = (state != Q_EMPTY);
   assign pop_data     = head;
   assign pop          = pop_valid && pop_ready && !clear;
   // A pop in the same cycle frees the slot; clear drops any request.
   assign push_ready_c = clear || (state != Q_FULL) || (pop_valid && pop_ready);
   assign push         = push_valid && push_ready_c && !clear;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= Q_EMPTY;
         head  <= '0;
         tail  <= '0;
      end else begin
         state <= state_nxt;
         head  <= head_nxt;
         tail  <= tail_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      head_nxt  = head;
      tail_nxt  = tail;
      if (clear) begin
         state_nxt = Q_EMPTY;
      end else begin
         case (state)
            Q_EMPTY: begin
               if (push) begin
                  head_nxt  = push_data;
                  state_nxt = Q_ONE;
               end
            end
            Q_ONE: begin
               if (push && pop) begin
                  head_nxt = push_data;
               end else if (push) begin
                  tail_nxt  = push_data;
                  state_nxt = Q_FULL;
               end else if (pop) begin
                  state_nxt = Q_EMPTY;
               end
            end
            Q_FULL: begin
               if (pop) begin
                  head_nxt = tail;
                  if (push) tail_nxt  = push_data;
                  else      state_nxt = Q_ONE;
               end
            end
            default: state_nxt = Q_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/inst_encoder.sv
// Packs decoded RV32I fields into instruction words, range-checks the immediate,
// and queues address-tagged results for the instruction-memory writer.
module inst_encoder
   import imm_enc_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned       ADDR_STEP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   inst_encoder_if.slave    bus,
   output logic [CNT_W-1:0] err_count
);

   logic [IMM_W-1:0]  imm;
   logic [INST_W-1:0] raw_inst_c;
   logic              legal_c;
   enc_word_t         word_c;
   enc_word_t         head;
   logic [$bits(enc_word_t)-1:0] head_bits;
   logic              accept;
   logic              out_fire;

   assign imm = bus.in_imm;

   // Field packing is the exact inverse of the immediate generator.
   always_comb begin
      raw_inst_c = NOP_INST;
      legal_c    = 1'b0;
      case (fmt_e'(bus.in_fmt))
         I_ALU: begin
            raw_inst_c = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_IMM};
            legal_c    = imm_fits(imm, 11);
         end
         I_SHIFT: begin
            raw_inst_c = {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_IMM};
            legal_c    = (imm[IMM_W-1:5] == '0) &&
                         ((bus.in_funct7 == F7_ZERO) || (bus.in_funct7 == F7_ALT));
         end
         I_LOAD: begin
            raw_inst_c = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
            legal_c    = imm_fits(imm, 11);
         end
         S: begin
            raw_inst_c = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], OP_STORE};
            legal_c    = imm_fits(imm, 11);
         end
         B: begin
            raw_inst_c = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          imm[4:1], imm[11], OP_BRANCH};
            legal_c    = imm_fits(imm, 12) && !imm[0];
         end
         JAL: begin
            raw_inst_c = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, OP_JAL};
            legal_c    = imm_fits(imm, 20) && !imm[0];
         end
         JALR: begin
            raw_inst_c = {imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, OP_JALR};
            legal_c    = imm_fits(imm, 11);
         end
         default: ;
      endcase
      word_c.err  = !legal_c;
      word_c.inst = legal_c ? raw_inst_c : NOP_INST;
   end

   enc_fifo2 #(.WIDTH($bits(enc_word_t))) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .push_valid   (bus.in_valid),
      .push_ready_c (bus.in_ready),
      .push_data    (word_c),
      .pop_valid    (bus.out_valid),
      .pop_ready    (bus.out_ready),
      .pop_data     (head_bits)
   );

   assign head         = enc_word_t'(head_bits);
   assign bus.out_inst = head.inst;
   assign bus.out_err  = head.err;

   assign accept   = bus.in_valid && bus.in_ready && !clear;
   assign out_fire = bus.out_valid && bus.out_ready && !clear;

   // Target address advances per delivered word and wraps naturally.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         bus.out_addr <= BASE_ADDR;
      end else if (out_fire) begin
         bus.out_addr <= bus.out_addr + ADDR_W'(ADDR_STEP);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         err_count <= '0;
      end else if (accept && word_c.err && (err_count != '1)) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed encodes, range errors, backpressure, clear and reset.
module tb_inst_encoder;
   import imm_enc_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] err_count;

   inst_encoder_if bus();

   inst_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .bus       (bus),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_addr;
   logic [15:0] exp_errs = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every handshake pops the oldest expected word.
   initial begin
      exp_t e;
      exp_addr = BASE;
      forever begin
         @(negedge clk);
         if (!rst_n || clear) begin
            exp_addr = BASE;
         end else if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got %h with nothing expected", bus.out_inst);
            end else begin
               e = exp_q.pop_front();
               chk("out_inst", bus.out_inst, e.inst);
               chk("out_err", 32'(bus.out_err), 32'(e.err));
               chk("out_addr", bus.out_addr, exp_addr);
               exp_addr = exp_addr + 32'd4;
            end
         end
      end
   end

   task automatic drive(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
      bus.in_fmt    = fmt;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_funct3 = f3;
      bus.in_funct7 = f7;
      bus.in_imm    = imm;
      bus.in_valid  = 1'b1;
   endtask

   task automatic send(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic [31:0] einst, input logic eerr);
      bit done = 1'b0;
      drive(fmt, rd, rs1, rs2, f3, f7, imm);
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back('{einst, eerr});
            if (eerr) exp_errs++;
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stuck 0, expected accept of %h", einst);
      end
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d words left, expected 0", exp_q.size());
      end
      step();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_out_inst"}, bus.out_inst, 32'd0);
      chk({tag, "_out_err"}, 32'(bus.out_err), 32'd0);
      chk({tag, "_out_addr"}, bus.out_addr, BASE);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_fmt    = '0;
      bus.in_rd     = '0;
      bus.in_rs1    = '0;
      bus.in_rs2    = '0;
      bus.in_funct3 = '0;
      bus.in_funct7 = '0;
      bus.in_imm    = '0;
      bus.out_ready = 1'b0;

      repeat (3) step();
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_vals("rst");

      step();
      bus.out_ready = 1'b1;
      send(I_ALU, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
      @(negedge clk);
      chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
      step();

      send(S,       5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'd8,         32'h0020_A423, 1'b0);
      send(B,       5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
      send(JAL,     5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2048,      32'h0010_00EF, 1'b0);
      send(I_SHIFT, 5'd5, 5'd5, 5'd0, 3'b101, 7'h20, 32'd3,         32'h4032_D293, 1'b0);
      send(JALR,    5'd1, 5'd2, 5'd0, 3'b111, 7'h00, 32'hFFFF_F800, 32'h8001_00E7, 1'b0);
      send(I_LOAD,  5'd3, 5'd2, 5'd0, 3'b010, 7'h00, 32'hFFFF_FFFC, 32'hFFC1_2183, 1'b0);
      send(JAL,     5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFF0_0000, 32'h8000_006F, 1'b0);
      drain();

      send(I_ALU,   5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2048, NOP, 1'b1);
      send(B,       5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'd3,    NOP, 1'b1);
      send(I_SHIFT, 5'd5, 5'd5, 5'd0, 3'b001, 7'h00, 32'd32,   NOP, 1'b1);
      drain();
      chk("err_count_3", 32'(err_count), 32'(exp_errs));

      send(3'd7,    5'd1, 5'd1, 5'd1, 3'b000, 7'h00, 32'd0,       NOP, 1'b1);
      send(I_SHIFT, 5'd5, 5'd5, 5'd0, 3'b101, 7'h01, 32'd3,       NOP, 1'b1);
      send(JAL,     5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'h0010_0000, NOP, 1'b1);
      drain();
      chk("err_count_6", 32'(err_count), 32'(exp_errs));

      // Backpressure: two words fill the queue, the third waits for a pop.
      bus.out_ready = 1'b0;
      send(I_LOAD, 5'd4, 5'd3, 5'd0, 3'b010, 7'h00, 32'd16, 32'h0101_A203, 1'b0);
      send(I_ALU,  5'd2, 5'd2, 5'd0, 3'b000, 7'h00, 32'd5,  32'h0051_0113, 1'b0);
      drive(S, 5'd0, 5'd1, 5'd3, 3'b010, 7'h00, 32'd4);
      @(negedge clk);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      chk("full_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_inst_0", bus.out_inst, 32'h0101_A203);
      @(negedge clk);
      chk("hold_inst_1", bus.out_inst, 32'h0101_A203);
      chk("hold_addr", bus.out_addr, exp_addr);
      step();
      bus.out_ready = 1'b1;
      send(S, 5'd0, 5'd1, 5'd3, 3'b010, 7'h00, 32'd4, 32'h0030_A223, 1'b0);
      drain();

      // Clear with a full queue and a simultaneous request that must be dropped.
      bus.out_ready = 1'b0;
      send(I_ALU, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd1,    32'h0010_0093, 1'b0);
      send(I_ALU, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd4096, NOP,           1'b1);
      clear = 1'b1;
      drive(I_ALU, 5'd7, 5'd0, 5'd0, 3'b000, 7'h00, 32'd7);
      exp_q.delete();
      exp_errs = '0;
      @(negedge clk);
      chk("clear_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      clear = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("clear_out_valid", 32'(bus.out_valid), 32'd0);
      chk("clear_out_addr", bus.out_addr, BASE);
      chk("clear_err_count", 32'(err_count), 32'(exp_errs));
      step();
      bus.out_ready = 1'b1;
      send(I_ALU, 5'd6, 5'd6, 5'd0, 3'b100, 7'h00, 32'hFFFF_FFFE, 32'hFFE3_4313, 1'b0);
      drain();

      // Reset mid-stream discards queued words.
      bus.out_ready = 1'b0;
      send(I_ALU, 5'd1, 5'd1, 5'd0, 3'b000, 7'h00, 32'd9,  32'h0090_8093, 1'b0);
      send(B,     5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5,  NOP,           1'b1);
      rst_n = 1'b0;
      exp_q.delete();
      exp_errs = '0;
      step();
      @(negedge clk);
      chk_reset_vals("midrst");
      step();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      send(I_ALU, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
